prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/loader_pkg.sv | 17 +
 rtl/word_packer.sv | 38 +++
 rtl/prog_loader.sv | 123 ++++++++++++
 tb/tb_prog_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader.
//   state_t  : loader FSM states
//   SYNC_DEF : default frame start byte
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_DEF = 8'hA5;

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembler.
//   clk, reset     : clock, async active-high reset
//   clr            : drops any partial word (byte counter back to 0)
//   byte_vld       : byte_in is valid this cycle
//   byte_in [7:0]  : incoming byte
//   word_nxt[31:0] : assembled word, valid when full=1
//   full           : this byte completes a word
module word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_nxt,
  output logic        full
);

  // Three earlier bytes; the oldest (byte 0) ends up in bits [7:0].
  logic [23:0] sr;
  logic [1:0]  bcnt;

  assign word_nxt = {byte_in, sr};
  assign full     = byte_vld && (bcnt == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (clr) begin
      sr   <= '0;
      bcnt <= '0;
    end else if (byte_vld) begin
      sr   <= {byte_in, sr[23:8]};
      bcnt <= bcnt + 2'd1;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: receives a framed image over a byte stream and
// writes it into instruction memory, holding the CPU in reset until a
// frame with a correct checksum has been fully loaded.
//   clk, reset      : clock, async active-high reset
//   rx_valid/rx_data: received byte strobe and data
//   we/wa/wd        : instruction-memory write port (one-cycle pulse per word)
//   cpu_reset       : high except after a successful load
//   done            : image loaded, checksum correct
//   err             : last frame rejected
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned WORDS   = 64,
  parameter int unsigned TIMEOUT = 100000,
  parameter logic [7:0]  SYNC    = SYNC_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     rx_valid,
  input  logic [7:0]               rx_data,
  output logic                     we,
  output logic [$clog2(WORDS)-1:0] wa,
  output logic [31:0]              wd,
  output logic                     cpu_reset,
  output logic                     done,
  output logic                     err
);

  localparam int AW = $clog2(WORDS);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0] ONE = 1;

  state_t        state, state_nxt;
  logic [AW:0]   idx;   // AW+1 bits so a full-depth count does not wrap
  logic [AW:0]   cnt;
  logic [7:0]    xr;
  logic [TW-1:0] idle;
  logic          in_frame, timeout, full, bad_cnt;
  logic [31:0]   word_nxt;

  assign in_frame = (state == COUNT) || (state == DATA) || (state == CSUM);
  assign timeout  = in_frame && !rx_valid && (idle == TW'(TIMEOUT - 1));
  assign bad_cnt  = (rx_data == 8'd0) || (32'(rx_data) > WORDS);

  // Packer only runs in DATA; leaving DATA (including on timeout) drops
  // any partial word.
  word_packer u_pack (
    .clk      (clk),
    .reset    (reset),
    .clr      (state != DATA),
    .byte_vld (rx_valid && (state == DATA)),
    .byte_in  (rx_data),
    .word_nxt (word_nxt),
    .full     (full)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (rx_valid && rx_data == SYNC) state_nxt = COUNT;
      COUNT: if (timeout)                     state_nxt = ERR;
             else if (rx_valid)               state_nxt = bad_cnt ? ERR : DATA;
      // Move on with the last word's 4th byte so a checksum byte arriving
      // during the write cycle is already seen in CSUM.
      DATA:  if (timeout)                     state_nxt = ERR;
             else if (full && (idx + ONE == cnt)) state_nxt = CSUM;
      CSUM:  if (timeout)                     state_nxt = ERR;
             else if (rx_valid)               state_nxt = (rx_data == xr) ? DONE : ERR;
      DONE:                                   state_nxt = DONE;
      ERR:   if (rx_valid && rx_data == SYNC) state_nxt = COUNT;
      default:                                state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    done      = (state == DONE);
    err       = (state == ERR);
    cpu_reset = (state != DONE);
  end

  // Datapath: counters, checksum and registered write port
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we   <= 1'b0;
      wa   <= '0;
      wd   <= '0;
      idx  <= '0;
      cnt  <= '0;
      xr   <= '0;
      idle <= '0;
    end else begin
      we <= 1'b0;
      if (!in_frame || rx_valid) idle <= '0;
      else                       idle <= idle + TW'(1);
      case (state)
        COUNT: if (rx_valid) begin
          cnt <= rx_data[AW:0];
          idx <= '0;
          xr  <= '0;
        end
        DATA: if (rx_valid) begin
          xr <= xr ^ rx_data;
          if (full) begin
            we  <= 1'b1;
            wa  <= idx[AW-1:0];
            wd  <= word_nxt;
            idx <= idx + ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        we, cpu_reset, done, err;
  logic [5:0]  wa;
  logic [31:0] wd;

  int checks = 0;
  int failures = 0;

  // write log filled by the monitor
  int          nwr = 0;
  logic [5:0]  wlog_a [0:127];
  logic [31:0] wlog_d [0:127];

  logic [7:0] buf_q [$];

  prog_loader #(.WORDS(64), .TIMEOUT(TO), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .we(we), .wa(wa), .wd(wd), .cpu_reset(cpu_reset), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we && nwr < 128) begin
      wlog_a[nwr] = wa;
      wlog_d[nwr] = wd;
      nwr = nwr + 1;
    end
  end

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  // send buf_q; b2b=1 keeps rx_valid high every cycle
  task automatic send_buf(input bit b2b);
    for (int i = 0; i < buf_q.size(); i++) begin
      put(buf_q[i]);
      if (!b2b) idle_cyc(1);
    end
    idle_cyc(3);
    buf_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    idle_cyc(2);
    reset = 1'b0;
    nwr = 0;
    idle_cyc(1);
  endtask

  // two-word frame; XOR of the eight data bytes is 0x80
  task automatic load_two(input logic [7:0] cs);
    buf_q = '{8'hA5, 8'h02, 8'h08, 8'h00, 8'h04, 8'h20, 8'h00, 8'h00, 8'h00, 8'hAC, cs};
  endtask

  task automatic check_two_writes(input string tag, input int base);
    checks++;
    if (wlog_a[base] !== 6'd0 || wlog_d[base] !== 32'h20040008) begin
      failures++;
      $display("FAIL %s w0: wa=%0d wd=%h want wa=0 wd=20040008", tag, wlog_a[base], wlog_d[base]);
    end
    checks++;
    if (wlog_a[base+1] !== 6'd1 || wlog_d[base+1] !== 32'hAC000000) begin
      failures++;
      $display("FAIL %s w1: wa=%0d wd=%h want wa=1 wd=ac000000", tag, wlog_a[base+1], wlog_d[base+1]);
    end
  endtask

  task automatic check_flags(input string tag, input logic d, input logic e, input logic cr);
    checks++;
    if (done !== d || err !== e || cpu_reset !== cr) begin
      failures++;
      $display("FAIL %s flags: done=%b err=%b cpu_reset=%b want %b %b %b",
               tag, done, err, cpu_reset, d, e, cr);
    end
  endtask

  task automatic check_nwr(input string tag, input int n);
    checks++;
    if (nwr !== n) begin
      failures++;
      $display("FAIL %s writes: got %0d want %0d", tag, nwr, n);
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (we !== 1'b0 || wa !== 6'd0 || wd !== 32'd0) begin
      failures++;
      $display("FAIL reset port: we=%b wa=%0d wd=%h want 0 0 0", we, wa, wd);
    end
    check_flags("reset", 1'b0, 1'b0, 1'b1);
    do_reset();
    check_flags("reset_rel", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_basic();
    do_reset();
    load_two(8'h80);
    send_buf(1'b0);
    check_nwr("basic", 2);
    check_two_writes("basic", 0);
    check_flags("basic", 1'b1, 1'b0, 1'b0);
    // bytes after DONE are ignored
    buf_q = '{8'hA5, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
    send_buf(1'b0);
    check_nwr("basic_ign", 2);
    check_flags("basic_ign", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_csum();
    do_reset();
    load_two(8'h89);
    send_buf(1'b0);
    check_nwr("badcs", 2);
    check_two_writes("badcs", 0);
    check_flags("badcs", 1'b0, 1'b1, 1'b1);
    load_two(8'h80);
    send_buf(1'b0);
    check_nwr("recover", 4);
    check_two_writes("recover", 2);
    check_flags("recover", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_bad_count();
    do_reset();
    buf_q = '{8'hA5, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    send_buf(1'b0);
    check_nwr("cnt0", 0);
    check_flags("cnt0", 1'b0, 1'b1, 1'b1);
    buf_q = '{8'hA5, 8'h41, 8'h01, 8'h02, 8'h03, 8'h04};
    send_buf(1'b0);
    check_nwr("cnt65", 0);
    check_flags("cnt65", 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_full_depth();
    int bad;
    logic [31:0] exp;
    do_reset();
    buf_q.push_back(8'hA5);
    buf_q.push_back(8'h40);
    for (int i = 0; i < 256; i++) buf_q.push_back(8'(i));
    buf_q.push_back(8'h00); // XOR of 0..255
    send_buf(1'b1);
    check_nwr("full", 64);
    bad = 0;
    for (int k = 0; k < 64; k++) begin
      exp = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
      checks++;
      if (wlog_a[k] !== 6'(k) || wlog_d[k] !== exp) begin
        failures++;
        if (bad < 4)
          $display("FAIL full w%0d: wa=%0d wd=%h want wa=%0d wd=%h", k, wlog_a[k], wlog_d[k], k, exp);
        bad++;
      end
    end
    check_flags("full", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_timeout_and_reset();
    do_reset();
    buf_q = '{8'hA5, 8'h01, 8'h11, 8'h22};
    for (int i = 0; i < buf_q.size(); i++) begin put(buf_q[i]); idle_cyc(1); end
    buf_q.delete();
    idle_cyc(TO - 4);
    check_flags("pre_to", 1'b0, 1'b0, 1'b1);
    idle_cyc(5);
    check_flags("timeout", 1'b0, 1'b1, 1'b1);
    check_nwr("timeout", 0);
    // the two remaining bytes land in ERR and must be ignored
    buf_q = '{8'h33, 8'h44};
    send_buf(1'b0);
    check_nwr("to_tail", 0);

    // reset pulsed mid-DATA
    do_reset();
    buf_q = '{8'hA5, 8'h01, 8'h11, 8'h22};
    for (int i = 0; i < buf_q.size(); i++) begin put(buf_q[i]); idle_cyc(1); end
    buf_q.delete();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (we !== 1'b0 || wa !== 6'd0 || wd !== 32'd0) begin
      failures++;
      $display("FAIL midrst port: we=%b wa=%0d wd=%h want 0 0 0", we, wa, wd);
    end
    check_flags("midrst", 1'b0, 1'b0, 1'b1);
    idle_cyc(2);
    reset = 1'b0;
    buf_q = '{8'h33, 8'h44, 8'h00};
    send_buf(1'b0);
    check_nwr("midrst", 0);
    check_flags("midrst_tail", 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_reset();
    buf_q = '{8'h00, 8'hFF};
    send_buf(1'b1);
    load_two(8'h80);
    send_buf(1'b1);
    check_nwr("b2b", 2);
    check_two_writes("b2b", 0);
    check_flags("b2b", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_bad_count();
    test_full_depth();
    test_timeout_and_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
